multicycle_state_sequencer: RTL

- State register and next-state logic for the multicycle RV32I core.
- Sits directly upstream of the per-state control decoder and drives its 4-bit current_state input.
- Sequences each instruction through fetch, decode, execute, memory and writeback, according to the opcode held in IR.
- Provides halt detection, illegal-opcode flagging, and retired-instruction and cycle counters.

---
 rtl/multicycle_state_sequencer_if.sv | 27 ++
 rtl/multicycle_state_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/multicycle_state_sequencer_if.sv
// Bundle of the control/status signals between the multicycle core and its
// state sequencer; the sequencer connects through the slave modport.
interface multicycle_state_sequencer_if #(
   parameter int CNT_WIDTH = 32
);
   logic [6:0]           opcode;
   logic                 halt_cond;
   logic                 mem_ready;
   logic [3:0]           current_state;
   logic                 is_halted;
   logic                 illegal_op;
   logic                 instr_retired;
   logic [CNT_WIDTH-1:0] retired_count;
   logic [CNT_WIDTH-1:0] cycle_count;

   modport master (
      output opcode, halt_cond, mem_ready,
      input  current_state, is_halted, illegal_op, instr_retired,
             retired_count, cycle_count
   );

   modport slave (
      input  opcode, halt_cond, mem_ready,
      output current_state, is_halted, illegal_op, instr_retired,
             retired_count, cycle_count
   );
endinterface

// File: rtl/multicycle_state_sequencer.sv
// State register and next-state logic of the multicycle RV32I core.
// Optional macro MEM_READY_HANDSHAKE_EN stalls IF_4/MEM_4 until mem_ready.
module multicycle_state_sequencer #(
   parameter int CNT_WIDTH = 32
) (
   input logic                          clk,
   input logic                          reset_n,
   multicycle_state_sequencer_if.slave  bus
);
   localparam logic [3:0] IF_1  = 4'd0;
   localparam logic [3:0] IF_2  = 4'd1;
   localparam logic [3:0] IF_3  = 4'd2;
   localparam logic [3:0] IF_4  = 4'd3;
   localparam logic [3:0] ID    = 4'd4;
   localparam logic [3:0] EX_1  = 4'd5;
   localparam logic [3:0] EX_2  = 4'd6;
   localparam logic [3:0] MEM_1 = 4'd7;
   localparam logic [3:0] MEM_2 = 4'd8;
   localparam logic [3:0] MEM_3 = 4'd9;
   localparam logic [3:0] MEM_4 = 4'd10;
   localparam logic [3:0] WB    = 4'd11;
   localparam logic [3:0] HALT  = 4'd12;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   logic [3:0]           state;
   logic [3:0]           next_state;
   logic [6:0]           op_q;
   logic                 illegal_next;
   logic                 retire_next;
   logic                 fetch_go;
   logic                 mem_go;
   logic                 illegal_q;
   logic                 retired_q;
   logic                 halted_q;
   logic [CNT_WIDTH-1:0] retired_cnt;
   logic [CNT_WIDTH-1:0] cycle_cnt;

`ifdef MEM_READY_HANDSHAKE_EN
   assign fetch_go = bus.mem_ready;
   assign mem_go   = bus.mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign fetch_go = 1'b1;
   assign mem_go   = 1'b1;
`endif

   always_comb begin
      next_state   = IF_1;
      illegal_next = 1'b0;
      retire_next  = 1'b0;
      case (state)
         IF_1:  next_state = IF_2;
         IF_2:  next_state = IF_3;
         IF_3:  next_state = IF_4;
         IF_4:  next_state = fetch_go ? ID : IF_4;
         // Live opcode decides here; op_q is only loaded on this same edge
         ID: begin
            case (bus.opcode)
               OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR,
               OP_LOAD, OP_STORE, OP_BRANCH: next_state = EX_1;
               OP_ECALL: begin
                  next_state  = bus.halt_cond ? HALT : WB;
                  retire_next = bus.halt_cond;
               end
               default: illegal_next = 1'b1;
            endcase
         end
         EX_1: begin
            case (op_q)
               OP_LOAD, OP_STORE: next_state = MEM_1;
               OP_BRANCH:         next_state = EX_2;
               default:           next_state = WB;
            endcase
         end
         EX_2: retire_next = 1'b1;
         MEM_1: next_state = MEM_2;
         MEM_2: next_state = MEM_3;
         MEM_3: next_state = MEM_4;
         MEM_4: begin
            if (!mem_go)
               next_state = MEM_4;
            else if (op_q == OP_STORE)
               retire_next = 1'b1;
            else
               next_state = WB;
         end
         WB:   retire_next = 1'b1;
         HALT: next_state  = HALT;
         default: next_state = IF_1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IF_1;
         op_q        <= 7'd0;
         illegal_q   <= 1'b0;
         retired_q   <= 1'b0;
         halted_q    <= 1'b0;
         retired_cnt <= '0;
         cycle_cnt   <= '0;
      end else begin
         state     <= next_state;
         illegal_q <= illegal_next;
         retired_q <= retire_next;
         halted_q  <= (next_state == HALT);
         if (state == ID)
            op_q <= bus.opcode;
         if (retire_next)
            retired_cnt <= retired_cnt + 1'b1;
         if (state != HALT)
            cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   assign bus.current_state = state;
   assign bus.is_halted     = halted_q;
   assign bus.illegal_op    = illegal_q;
   assign bus.instr_retired = retired_q;
   assign bus.retired_count = retired_cnt;
   assign bus.cycle_count   = cycle_cnt;
endmodule
